stage_if: RTL and testbench
===========================

Name: stage_if

Overview:
- Multithreaded instruction-fetch stage; produces the IF/ID pipeline register consumed by the decode stage.
- Holds one PC per hardware thread and picks a fetchable thread round-robin each cycle.
- Issues that thread's PC to the I-cache/I-TLB, then registers instruction, PC, thread id and miss flags toward decode.
- Accepts branch/jump redirects and exception redirects from later stages, and a stall from the decode hazard logic.

Parameters:
N_THREADS, 4, number of hardware threads; thread id width TW = clog2(N_THREADS)
PC_RESET, 32'h0000_1000, per-thread PC after reset
EXC_VECTOR, 32'h0000_2000, PC loaded on exception redirect
NOP_WORD, 32'h0000_0000, instruction word driven on bubbles

Ports:
clk  in  1  clock
rst  in  1  reset
stall  in  1  decode cannot accept; hold IF/ID register
redir_valid  in  1  branch/jump redirect
redir_thread  in  TW  thread being redirected
redir_pc  in  32  new PC
exc_valid  in  1  exception taken
exc_thread  in  TW  thread taking exception
ic_req  out  1  fetch request this cycle
ic_vaddr  out  32  fetch virtual address
ic_thread  out  TW  requesting thread
ic_hit  in  1  same-cycle response: instruction valid
ic_data  in  32  instruction word
ic_miss  in  1  same-cycle response: I-cache miss, fill started
itlb_miss  in  1  same-cycle response: I-TLB miss (priority over ic_miss/ic_hit)
fill_done  in  1  I-cache fill finished
fill_thread  in  TW  thread whose fill finished
id_valid  out  1  IF/ID holds a real instruction
id_pc  out  32  PC of fetched instruction
id_instruction  out  32  instruction word
id_thread  out  TW  thread id
id_itlb_miss  out  1  fetch faulted in I-TLB
id_icache_miss  out  1  fetch missed in I-cache

Behaviour:
Reset (rst=1 at posedge):
- All PCs = PC_RESET; all threads READY; rr pointer = N_THREADS-1, so thread 0 is fetched first.
- id_valid, id_itlb_miss, id_icache_miss = 0; id_pc = 0; id_thread = 0; id_instruction = NOP_WORD.
- ic_req = 0 while rst is high.
- Reset mid-fill discards all thread states; a later fill_done is ignored.

Per-thread state machine:
- READY -> WAIT_FILL when a fetch gets ic_miss.
- READY -> WAIT_EXC when a fetch gets itlb_miss.
- WAIT_FILL -> READY on fill_done with fill_thread == t. PC is unchanged, so the refetch hits.
- WAIT_EXC -> READY only on exc_valid for t.
- Any state -> READY on redir_valid or exc_valid for t.

Selection (combinational):
- If stall = 0, pick the first READY thread after the rr pointer (wrapping), excluding any thread named by redir_valid/exc_valid this cycle.
- If one is found: ic_req = 1, ic_vaddr = pc[t], ic_thread = t.
- If none is found: ic_req = 0.
- If stall = 1: ic_req = 0.

Update at posedge (stall = 0), response checked in priority order itlb_miss > ic_miss > ic_hit:
- Hit: id_valid = 1, id_instruction = ic_data, id_pc = pc[t], id_thread = t, miss flags 0; pc[t] += 4 (wraps mod 2^32); rr pointer = t.
- ic_miss: id_valid = 0, id_icache_miss = 1, id_instruction = NOP_WORD, id_pc/id_thread = faulting PC/thread; rr pointer = t.
- itlb_miss: id_valid = 0, id_itlb_miss = 1, id_pc/id_thread = faulting PC/thread; rr pointer = t.
- No request, or no response asserted: bubble (id_valid = 0, flags 0, NOP_WORD).

Stall:
- IF/ID outputs and the rr pointer hold; PCs change only by redirect/exception.
- Redirects still apply during stall.

Redirects:
- redir_valid: pc[redir_thread] = redir_pc.
- exc_valid: pc[exc_thread] = EXC_VECTOR.
- Same thread in both: exception wins.
- If the registered IF/ID entry belongs to a redirected thread and stall = 1, it is squashed: id_valid and flags cleared.
- fill_done for a thread already redirected to READY is ignored.

Latency: one cycle from ic_req to IF/ID output.

Test Plan:
- Reset, all ic_hit=1, ic_data=pc: id_thread 0,1,2,3,0..., id_pc 1000,1000,1000,1000,1004; id_valid=1 every cycle from the 2nd cycle.
- Thread 1 gets ic_miss at pc 1000: id_icache_miss=1, id_valid=0 that cycle; sequence skips thread 1 (0,2,3,0...); after fill_done (fill_thread=1), thread 1 refetches pc 1000.
- Thread 2 gets itlb_miss: id_itlb_miss=1, id_pc=1000; thread 2 is not fetched until exc_valid (exc_thread=2); next fetch from thread 2 is at pc 2000.
- stall=1 for 3 cycles with redir_valid (thread 0, pc 0x4000) in cycle 2: outputs frozen, ic_req=0; first thread-0 fetch after stall is at 0x4000.
- Simultaneous redir_valid and exc_valid on thread 3: pc[3]=2000; thread 3 is not selected in that same cycle.
- rst asserted while thread 1 is in WAIT_FILL: all PCs=1000, thread 1 READY; a following fill_done changes nothing.

Source files
------------

// File: rtl/stage_if.sv
// Multithreaded instruction-fetch stage.
// Keeps one PC and one fetch state per hardware thread and picks a fetchable
// thread round-robin each cycle. The selected PC goes to the I-cache/I-TLB,
// and the same-cycle response is registered into the IF/ID pipeline register
// that feeds decode. Branch/jump redirects and exception redirects from later
// stages rewrite per-thread PCs, and a decode stall freezes IF/ID.
module stage_if #(
    parameter int unsigned N_THREADS  = 4,
    parameter logic [31:0] PC_RESET   = 32'h0000_1000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_2000,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000,
    localparam int unsigned TW        = (N_THREADS > 1) ? $clog2(N_THREADS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          redir_valid,
    input  logic [TW-1:0] redir_thread,
    input  logic [31:0]   redir_pc,
    input  logic          exc_valid,
    input  logic [TW-1:0] exc_thread,
    output logic          ic_req,
    output logic [31:0]   ic_vaddr,
    output logic [TW-1:0] ic_thread,
    input  logic          ic_hit,
    input  logic [31:0]   ic_data,
    input  logic          ic_miss,
    input  logic          itlb_miss,
    input  logic          fill_done,
    input  logic [TW-1:0] fill_thread,
    output logic          id_valid,
    output logic [31:0]   id_pc,
    output logic [31:0]   id_instruction,
    output logic [TW-1:0] id_thread,
    output logic          id_itlb_miss,
    output logic          id_icache_miss
);

    typedef enum logic [1:0] {
        TS_READY     = 2'd0,
        TS_WAIT_FILL = 2'd1,
        TS_WAIT_EXC  = 2'd2
    } thr_state_e;

    // Per-thread architectural fetch state
    thr_state_e    r_state [N_THREADS];
    logic [31:0]   r_pc    [N_THREADS];
    thr_state_e    w_state_nxt [N_THREADS];
    logic [31:0]   w_pc_nxt    [N_THREADS];

    // Round-robin pointer: last thread that received a fetch response
    logic [TW-1:0] r_rr;

    // IF/ID pipeline register
    logic          r_id_valid;
    logic [31:0]   r_id_pc;
    logic [31:0]   r_id_instruction;
    logic [TW-1:0] r_id_thread;
    logic          r_id_itlb_miss;
    logic          r_id_icache_miss;

    // Selection results
    logic [N_THREADS-1:0] w_excl;
    logic                 w_found;
    logic [TW-1:0]        w_sel;
    logic [31:0]          w_sel_pc;
    logic                 w_got_resp;

    // Threads touched by a redirect this cycle are excluded from selection
    always_comb begin
        w_excl = '0;
        for (int unsigned t = 0; t < N_THREADS; t++) begin
            w_excl[t] = (redir_valid && (redir_thread == TW'(t))) ||
                        (exc_valid   && (exc_thread   == TW'(t)));
        end
    end

    // Round-robin pick of the first READY, non-redirected thread after r_rr
    always_comb begin
        int unsigned idx;
        w_found  = 1'b0;
        w_sel    = '0;
        w_sel_pc = '0;
        idx      = 0;
        if (!rst && !stall) begin
            for (int unsigned i = 1; i <= N_THREADS; i++) begin
                idx = (32'(r_rr) + i) % N_THREADS;
                if (!w_found && (r_state[idx] == TS_READY) && !w_excl[idx]) begin
                    w_found  = 1'b1;
                    w_sel    = TW'(idx);
                    w_sel_pc = r_pc[idx];
                end
            end
        end
    end

    assign ic_req     = w_found;
    assign ic_vaddr   = w_sel_pc;
    assign ic_thread  = w_sel;
    assign w_got_resp = w_found && (itlb_miss || ic_miss || ic_hit);

    // Next thread state and PC: fetch outcome, fill completion, then redirects
    always_comb begin
        for (int unsigned t = 0; t < N_THREADS; t++) begin
            w_state_nxt[t] = r_state[t];
            w_pc_nxt[t]    = r_pc[t];
            if (w_found && (w_sel == TW'(t))) begin
                if (itlb_miss) begin
                    w_state_nxt[t] = TS_WAIT_EXC;
                end else if (ic_miss) begin
                    w_state_nxt[t] = TS_WAIT_FILL;
                end else if (ic_hit) begin
                    w_pc_nxt[t] = r_pc[t] + 32'd4;
                end
            end else if ((r_state[t] == TS_WAIT_FILL) && fill_done &&
                         (fill_thread == TW'(t))) begin
                w_state_nxt[t] = TS_READY;
            end
            // Exception is applied last so it wins over a same-thread redirect
            if (redir_valid && (redir_thread == TW'(t))) begin
                w_state_nxt[t] = TS_READY;
                w_pc_nxt[t]    = redir_pc;
            end
            if (exc_valid && (exc_thread == TW'(t))) begin
                w_state_nxt[t] = TS_READY;
                w_pc_nxt[t]    = EXC_VECTOR;
            end
        end
    end

    // Thread state and PC registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned t = 0; t < N_THREADS; t++) begin
                r_state[t] <= TS_READY;
                r_pc[t]    <= PC_RESET;
            end
        end else begin
            for (int unsigned t = 0; t < N_THREADS; t++) begin
                r_state[t] <= w_state_nxt[t];
                r_pc[t]    <= w_pc_nxt[t];
            end
        end
    end

    // Round-robin pointer advances only when the picked thread got a response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr <= TW'(N_THREADS - 1);
        end else if (w_got_resp) begin
            r_rr <= w_sel;
        end
    end

    // IF/ID register: load response, bubble, or hold/squash under stall
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_valid       <= 1'b0;
            r_id_pc          <= '0;
            r_id_instruction <= NOP_WORD;
            r_id_thread      <= '0;
            r_id_itlb_miss   <= 1'b0;
            r_id_icache_miss <= 1'b0;
        end else if (!stall) begin
            if (w_got_resp) begin
                r_id_pc     <= w_sel_pc;
                r_id_thread <= w_sel;
                if (itlb_miss) begin
                    r_id_valid       <= 1'b0;
                    r_id_instruction <= NOP_WORD;
                    r_id_itlb_miss   <= 1'b1;
                    r_id_icache_miss <= 1'b0;
                end else if (ic_miss) begin
                    r_id_valid       <= 1'b0;
                    r_id_instruction <= NOP_WORD;
                    r_id_itlb_miss   <= 1'b0;
                    r_id_icache_miss <= 1'b1;
                end else begin
                    r_id_valid       <= 1'b1;
                    r_id_instruction <= ic_data;
                    r_id_itlb_miss   <= 1'b0;
                    r_id_icache_miss <= 1'b0;
                end
            end else begin
                r_id_valid       <= 1'b0;
                r_id_instruction <= NOP_WORD;
                r_id_itlb_miss   <= 1'b0;
                r_id_icache_miss <= 1'b0;
            end
        end else if (w_excl[r_id_thread]) begin
            // Held entry belongs to a thread being redirected: kill it in place
            r_id_valid       <= 1'b0;
            r_id_itlb_miss   <= 1'b0;
            r_id_icache_miss <= 1'b0;
        end
    end

    assign id_valid       = r_id_valid;
    assign id_pc          = r_id_pc;
    assign id_instruction = r_id_instruction;
    assign id_thread      = r_id_thread;
    assign id_itlb_miss   = r_id_itlb_miss;
    assign id_icache_miss = r_id_icache_miss;

endmodule

// File: tb/tb_stage_if.sv
// Directed testbench for stage_if: a small I-cache responder answers with the
// fetch address as the instruction word, and per-thread masks inject misses.
module tb_stage_if;

    localparam int unsigned TW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic          redir_valid;
    logic [TW-1:0] redir_thread;
    logic [31:0]   redir_pc;
    logic          exc_valid;
    logic [TW-1:0] exc_thread;
    logic          ic_req;
    logic [31:0]   ic_vaddr;
    logic [TW-1:0] ic_thread;
    logic          ic_hit;
    logic [31:0]   ic_data;
    logic          ic_miss;
    logic          itlb_miss;
    logic          fill_done;
    logic [TW-1:0] fill_thread;
    logic          id_valid;
    logic [31:0]   id_pc;
    logic [31:0]   id_instruction;
    logic [TW-1:0] id_thread;
    logic          id_itlb_miss;
    logic          id_icache_miss;

    logic [3:0]    itlb_mask;
    logic [3:0]    icm_mask;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    stage_if #(
        .N_THREADS  (4),
        .PC_RESET   (32'h0000_1000),
        .EXC_VECTOR (32'h0000_2000),
        .NOP_WORD   (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redir_valid    (redir_valid),
        .redir_thread   (redir_thread),
        .redir_pc       (redir_pc),
        .exc_valid      (exc_valid),
        .exc_thread     (exc_thread),
        .ic_req         (ic_req),
        .ic_vaddr       (ic_vaddr),
        .ic_thread      (ic_thread),
        .ic_hit         (ic_hit),
        .ic_data        (ic_data),
        .ic_miss        (ic_miss),
        .itlb_miss      (itlb_miss),
        .fill_done      (fill_done),
        .fill_thread    (fill_thread),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instruction (id_instruction),
        .id_thread      (id_thread),
        .id_itlb_miss   (id_itlb_miss),
        .id_icache_miss (id_icache_miss)
    );

    // Same-cycle cache/TLB responder
    assign itlb_miss = ic_req && itlb_mask[ic_thread];
    assign ic_miss   = ic_req && icm_mask[ic_thread];
    assign ic_hit    = ic_req && !itlb_miss && !ic_miss;
    assign ic_data   = ic_vaddr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_id(input string tag, input logic v, input logic [1:0] t,
                          input logic [31:0] pc, input logic [31:0] instr,
                          input logic tl, input logic cm);
        check({tag, " id_valid"},       32'(id_valid),       32'(v));
        check({tag, " id_thread"},      32'(id_thread),      32'(t));
        check({tag, " id_pc"},          id_pc,               pc);
        check({tag, " id_instruction"}, id_instruction,      instr);
        check({tag, " id_itlb_miss"},   32'(id_itlb_miss),   32'(tl));
        check({tag, " id_icache_miss"}, 32'(id_icache_miss), 32'(cm));
    endtask

    task automatic fetch(input string tag, input logic [1:0] t, input logic [31:0] pc);
        step();
        chk_id(tag, 1'b1, t, pc, pc, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0;
        redir_valid = 1'b0; redir_thread = '0; redir_pc = '0;
        exc_valid = 1'b0; exc_thread = '0;
        fill_done = 1'b0; fill_thread = '0;
        itlb_mask = '0; icm_mask = '0;

        // Reset state
        step(); step();
        check("rst ic_req", 32'(ic_req), 32'd0);
        chk_id("rst", 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Round-robin hits starting at thread 0
        rst = 1'b0;
        #1;
        check("first ic_req",    32'(ic_req),    32'd1);
        check("first ic_thread", 32'(ic_thread), 32'd0);
        check("first ic_vaddr",  ic_vaddr,       32'h1000);
        for (int k = 0; k < 8; k++)
            fetch("rr", 2'(k % 4), 32'h1000 + 32'(4 * (k / 4)));

        // I-cache miss on thread 1 and fill
        icm_mask = 4'b0010;
        fetch("icm t0", 2'd0, 32'h1008);
        step();
        chk_id("icm t1", 1'b0, 2'd1, 32'h1008, 32'h0, 1'b0, 1'b1);
        fetch("icm t2", 2'd2, 32'h1008);
        fetch("icm t3", 2'd3, 32'h1008);
        fetch("icm t0b", 2'd0, 32'h100c);
        fetch("icm skip", 2'd2, 32'h100c);
        icm_mask = '0; fill_done = 1'b1; fill_thread = 2'd1;
        fetch("fill t3", 2'd3, 32'h100c);
        fill_done = 1'b0;
        fetch("fill t0", 2'd0, 32'h1010);
        fetch("refetch t1", 2'd1, 32'h1008);

        // I-TLB miss on thread 2, resolved by exception
        itlb_mask = 4'b0100;
        step();
        chk_id("itlb t2", 1'b0, 2'd2, 32'h1010, 32'h0, 1'b1, 1'b0);
        itlb_mask = '0;
        fetch("itlb t3", 2'd3, 32'h1010);
        fetch("itlb t0", 2'd0, 32'h1014);
        fetch("itlb t1", 2'd1, 32'h100c);
        fetch("itlb skip", 2'd3, 32'h1014);
        exc_valid = 1'b1; exc_thread = 2'd2;
        fetch("exc t0", 2'd0, 32'h1018);
        exc_valid = 1'b0;
        fetch("exc t1", 2'd1, 32'h1010);
        fetch("exc t2", 2'd2, 32'h2000);

        // Stall for 3 cycles with a redirect of thread 0 in the middle
        stall = 1'b1;
        #1;
        check("stall ic_req", 32'(ic_req), 32'd0);
        step();
        chk_id("stall c1", 1'b1, 2'd2, 32'h2000, 32'h2000, 1'b0, 1'b0);
        redir_valid = 1'b1; redir_thread = 2'd0; redir_pc = 32'h4000;
        #1;
        check("stall redir ic_req", 32'(ic_req), 32'd0);
        step();
        chk_id("stall c2", 1'b1, 2'd2, 32'h2000, 32'h2000, 1'b0, 1'b0);
        redir_valid = 1'b0;
        step();
        chk_id("stall c3", 1'b1, 2'd2, 32'h2000, 32'h2000, 1'b0, 1'b0);
        stall = 1'b0;
        fetch("post stall t3", 2'd3, 32'h1018);
        fetch("post stall t0", 2'd0, 32'h4000);

        // Stall with redirect of the thread held in IF/ID squashes it
        stall = 1'b1; redir_valid = 1'b1; redir_thread = 2'd0; redir_pc = 32'h5000;
        step();
        chk_id("squash", 1'b0, 2'd0, 32'h4000, 32'h4000, 1'b0, 1'b0);
        stall = 1'b0; redir_valid = 1'b0;
        fetch("sq t1", 2'd1, 32'h1014);
        fetch("sq t2", 2'd2, 32'h2004);
        fetch("sq t3", 2'd3, 32'h101c);
        fetch("sq t0", 2'd0, 32'h5000);

        // Redirect and exception together on thread 3
        fetch("dual t1", 2'd1, 32'h1018);
        fetch("dual t2", 2'd2, 32'h2008);
        redir_valid = 1'b1; redir_thread = 2'd3; redir_pc = 32'h6000;
        exc_valid = 1'b1; exc_thread = 2'd3;
        #1;
        check("dual ic_thread", 32'(ic_thread), 32'd0);
        fetch("dual t0", 2'd0, 32'h5004);
        redir_valid = 1'b0; exc_valid = 1'b0;
        fetch("dual t1b", 2'd1, 32'h101c);
        fetch("dual t2b", 2'd2, 32'h200c);
        fetch("dual t3", 2'd3, 32'h2000);

        // Reset while thread 1 waits on a fill; late fill_done is ignored
        icm_mask = 4'b0010;
        fetch("mid t0", 2'd0, 32'h5008);
        step();
        chk_id("mid icm t1", 1'b0, 2'd1, 32'h1020, 32'h0, 1'b0, 1'b1);
        icm_mask = '0; rst = 1'b1;
        step();
        check("mid rst ic_req", 32'(ic_req), 32'd0);
        chk_id("mid rst", 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0; fill_done = 1'b1; fill_thread = 2'd1;
        #1;
        check("mid ic_vaddr", ic_vaddr, 32'h1000);
        fetch("mid r t0", 2'd0, 32'h1000);
        fill_done = 1'b0;
        fetch("mid r t1", 2'd1, 32'h1000);
        fetch("mid r t2", 2'd2, 32'h1000);
        fetch("mid r t3", 2'd3, 32'h1000);
        fetch("mid r t0b", 2'd0, 32'h1004);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
